forwarding_pipe_unit: RTL and testbench
=======================================

// Module: forwarding_pipe_unit
// PURPOSE
//  Parametrised bypass unit for the EX/MEM/WB datapath. Holds a DEPTH-deep shift
//  pipeline of in-flight results (dest, data, ready). For each of NUM_RD read
//  ports it returns the youngest matching in-flight value, or the register-file
//  value if none matches. Raises a load-use stall when the youngest match is an
//  unresolved load. Counts stall cycles with a saturating counter.
// PARAMETERS
//  DATA_W   16  datapath width
//  ADDR_W   3   register address width
//  DEPTH    2   in-flight stages tracked, >=2; stage 0 = youngest
//  NUM_RD   2   read ports
//  ZERO_REG 1   1: address 0 never forwards; always returns rf data (0)
//  CNT_W    16  stall counter width
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  ex_valid   in   1              result issued this cycle from EX
//  ex_dest    in   ADDR_W         destination register of EX result
//  ex_data    in   DATA_W         EX result (ignored when ex_is_load)
//  ex_is_load in   1              EX op is a load; data arrives next cycle
//  mem_data   in   DATA_W         load data for the entry now in stage 0
//  rd_addr    in   NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rf_data    in   NUM_RD*DATA_W  register-file read data, same packing
//  fwd_data   out  NUM_RD*DATA_W  forwarded operand per port
//  fwd_hit    out  NUM_RD         1: port value came from pipeline, not rf
//  stall      out  1              load-use hazard; upstream holds EX inputs
//  stall_cnt  out  CNT_W          saturating count of stall cycles
// BEHAVIOUR
//  Entry e[k] = {valid, dest, data, ready}, k = 0..DEPTH-1.
//  Every clock, when not rst:
//   - e[k] <= e[k-1] for k >= 1. Stage 0 -> 1 transfer: if e[0].valid and not
//     e[0].ready, e[1].data <= mem_data and e[1].ready <= 1.
//   - If stall = 0: e[0] <= {ex_valid, ex_dest, ex_data, !ex_is_load}.
//   - If stall = 1: e[0] <= bubble (valid = 0). EX inputs are not captured.
//  Read port i, combinational from registered entries:
//   - Match k: e[k].valid, e[k].dest == rd_addr[i]; (ZERO_REG and addr == 0)
//     never matches.
//   - Lowest matching k wins (youngest). fwd_hit[i] = 1. fwd_data[i] = e[k].data.
//   - No match: fwd_hit[i] = 0 and fwd_data[i] = rf_data[i].
//   - Winning entry not ready: fwd_data[i] = rf_data[i], fwd_hit[i] = 0, and the
//     port requests a stall.
//  stall = OR of per-port stall requests. Combinational, same cycle.
//  Only stage 0 can hold an unready entry, so a load-use stall lasts exactly
//  1 cycle.
//  stall_cnt increments on each clock with stall = 1. Holds at 2^CNT_W-1.
//  Reset: all e[k].valid = 0, ready = 1, data = 0, dest = 0; stall_cnt = 0.
//  Outputs after reset: fwd_hit = 0, fwd_data = rf_data, stall = 0.
//  Reset mid-operation discards all in-flight entries. A pending load is dropped
//  and never forwarded.
//  Back-to-back writes to the same dest: the younger value wins.
//  A write leaving stage DEPTH-1 is no longer visible. It must already be in
//  the rf.
// TESTING
//  1 Reset, rd_addr = {3,2}, rf_data = {0x1111,0x2222}
//    -> fwd_hit = 0, fwd_data = rf_data, stall = 0, stall_cnt = 0.
//  2 EX r2 <= 0x00AA, then next cycle read r2
//    -> fwd_hit[0] = 1, fwd_data = 0x00AA.
//    One cycle later -> still hit from stage 1.
//  3 EX r5 <= 0x1, then r5 <= 0x2. Read r5
//    -> 0x2 (youngest), not 0x1.
//  4 Load r4, next cycle read r4
//    -> stall = 1 for exactly 1 cycle, bubble inserted.
//    mem_data = 0xBEEF -> next cycle fwd_data = 0xBEEF, hit = 1, stall_cnt = 1.
//  5 EX r0 <= 0x5555 with ZERO_REG = 1, read r0
//    -> fwd_hit = 0, fwd_data = rf_data.
//  6 Load r1, assert rst in the next cycle
//    -> no stall, no hits, stall_cnt = 0.
//    Force 2^CNT_W+3 stalls -> stall_cnt saturates at all-ones.

Source files
------------

// File: rtl/forwarding_pipe_unit.sv
// Bypass unit: tracks DEPTH in-flight results and forwards the youngest match
// to each read port, raising a one-cycle load-use stall on an unresolved load.
module forwarding_pipe_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic [ADDR_W-1:0]        ex_dest,
  input  logic [DATA_W-1:0]        ex_data,
  input  logic                     ex_is_load,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [ADDR_W-1:0] dest_q  [DEPTH];
  logic [ADDR_W-1:0] dest_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic              ready_q [DEPTH];
  logic              ready_d [DEPTH];

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;
  logic [NUM_RD-1:0] stall_req;

  // Per-port youngest-match lookup; an unready winner falls back to rf data and stalls.
  always_comb begin
    logic              found;
    logic              win_ready;
    logic [DATA_W-1:0] win_data;
    logic [ADDR_W-1:0] addr;
    fwd_data  = '0;
    fwd_hit   = '0;
    stall_req = '0;
    found     = 1'b0;
    win_ready = 1'b1;
    win_data  = '0;
    addr      = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      found     = 1'b0;
      win_ready = 1'b1;
      win_data  = '0;
      addr      = rd_addr[i*ADDR_W +: ADDR_W];
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (!found && valid_q[k] && (dest_q[k] == addr) &&
            !((ZERO_REG != 0) && (addr == '0))) begin
          found     = 1'b1;
          win_ready = ready_q[k];
          win_data  = data_q[k];
        end
      end
      if (found && win_ready) begin
        fwd_hit[i]                  = 1'b1;
        fwd_data[i*DATA_W +: DATA_W] = win_data;
      end else begin
        fwd_data[i*DATA_W +: DATA_W] = rf_data[i*DATA_W +: DATA_W];
      end
      stall_req[i] = found && !win_ready;
    end
  end

  assign stall     = |stall_req;
  assign stall_cnt = stall_cnt_q;

  // Next pipeline contents: shift, resolve a pending load on its way to stage 1, insert EX or a bubble.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      valid_d[k] = 1'b0;
      dest_d[k]  = '0;
      data_d[k]  = '0;
      ready_d[k] = 1'b1;
    end
    if (!stall) begin
      valid_d[0] = ex_valid;
      dest_d[0]  = ex_dest;
      data_d[0]  = ex_is_load ? '0 : ex_data;
      ready_d[0] = !ex_is_load;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      valid_d[k] = valid_q[k-1];
      dest_d[k]  = dest_q[k-1];
      data_d[k]  = data_q[k-1];
      ready_d[k] = ready_q[k-1];
    end
    if (valid_q[0] && !ready_q[0]) begin
      data_d[1]  = mem_data;
      ready_d[1] = 1'b1;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; reset drops all in-flight entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        valid_q[k] <= 1'b0;
        dest_q[k]  <= '0;
        data_q[k]  <= '0;
        ready_q[k] <= 1'b1;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        valid_q[k] <= valid_d[k];
        dest_q[k]  <= dest_d[k];
        data_q[k]  <= data_d[k];
        ready_q[k] <= ready_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_forwarding_pipe_unit.sv
// Directed bench for forwarding_pipe_unit (2 read ports, depth 2, 4-bit stall counter).
module tb_forwarding_pipe_unit;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned CNT_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ex_valid;
  logic [ADDR_W-1:0]        ex_dest;
  logic [DATA_W-1:0]        ex_data;
  logic                     ex_is_load;
  logic [DATA_W-1:0]        mem_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rf_data;
  logic [NUM_RD*DATA_W-1:0] fwd_data;
  logic [NUM_RD-1:0]        fwd_hit;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  int checks = 0;
  int errors = 0;

  forwarding_pipe_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2), .NUM_RD(NUM_RD),
    .ZERO_REG(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_dest(ex_dest),
    .ex_data(ex_data), .ex_is_load(ex_is_load), .mem_data(mem_data),
    .rd_addr(rd_addr), .rf_data(rf_data), .fwd_data(fwd_data),
    .fwd_hit(fwd_hit), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs settle away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_dest = '0; ex_data = '0; ex_is_load = 1'b0;
    mem_data = '0;
    rd_addr = {3'd3, 3'd2};
    rf_data = {16'h1111, 16'h2222};
    step(); step();
    checks++;
    if (fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_hit got %b want 00", fwd_hit); end
    checks++;
    if (fwd_data !== 32'h1111_2222) begin errors++; $display("FAIL reset_data got %h want 11112222", fwd_data); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_forward();
    ex_valid = 1'b1; ex_dest = 3'd2; ex_data = 16'h00AA; ex_is_load = 1'b0;
    step();
    ex_valid = 1'b0;
    rd_addr = {3'd3, 3'd2};
    #1;
    checks++;
    if (fwd_hit !== 2'b01) begin errors++; $display("FAIL fwd_s0_hit got %b want 01", fwd_hit); end
    checks++;
    if (fwd_data !== 32'h1111_00AA) begin errors++; $display("FAIL fwd_s0_data got %h want 111100aa", fwd_data); end
    step();
    checks++;
    if (fwd_hit !== 2'b01 || fwd_data[15:0] !== 16'h00AA) begin
      errors++; $display("FAIL fwd_s1 got hit %b data %h want 01 00aa", fwd_hit, fwd_data[15:0]);
    end
    step();
    checks++;
    if (fwd_hit !== 2'b00 || fwd_data[15:0] !== 16'h2222) begin
      errors++; $display("FAIL fwd_retired got hit %b data %h want 00 2222", fwd_hit, fwd_data[15:0]);
    end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; ex_dest = 3'd5; ex_data = 16'h0001; ex_is_load = 1'b0;
    step();
    ex_data = 16'h0002;
    step();
    ex_valid = 1'b0;
    rd_addr = {3'd5, 3'd5};
    #1;
    checks++;
    if (fwd_hit !== 2'b11 || fwd_data !== 32'h0002_0002) begin
      errors++; $display("FAIL b2b_youngest got hit %b data %h want 11 00020002", fwd_hit, fwd_data);
    end
    step();
    checks++;
    if (fwd_hit !== 2'b11 || fwd_data !== 32'h0002_0002) begin
      errors++; $display("FAIL b2b_stage1 got hit %b data %h want 11 00020002", fwd_hit, fwd_data);
    end
    step();
  endtask

  task automatic test_load_use();
    ex_valid = 1'b1; ex_dest = 3'd4; ex_data = 16'h7777; ex_is_load = 1'b1;
    step();
    // EX presents r3 during the stall; it must not be captured.
    ex_valid = 1'b1; ex_dest = 3'd3; ex_data = 16'h3333; ex_is_load = 1'b0;
    rd_addr = {3'd3, 3'd4};
    mem_data = 16'hBEEF;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
    checks++;
    if (fwd_hit !== 2'b00 || fwd_data !== 32'h1111_2222) begin
      errors++; $display("FAIL lu_stall_data got hit %b data %h want 00 11112222", fwd_hit, fwd_data);
    end
    step();
    ex_valid = 1'b0;
    mem_data = 16'h0000;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %b want 0", stall); end
    checks++;
    if (fwd_hit !== 2'b01 || fwd_data !== 32'h1111_BEEF) begin
      errors++; $display("FAIL lu_fwd got hit %b data %h want 01 1111beef", fwd_hit, fwd_data);
    end
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
    step();
  endtask

  task automatic test_zero_reg();
    ex_valid = 1'b1; ex_dest = 3'd0; ex_data = 16'h5555; ex_is_load = 1'b0;
    step();
    ex_valid = 1'b0;
    rd_addr = {3'd0, 3'd0};
    #1;
    checks++;
    if (fwd_hit !== 2'b00 || fwd_data !== 32'h1111_2222) begin
      errors++; $display("FAIL zero_reg got hit %b data %h want 00 11112222", fwd_hit, fwd_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_dest = 3'd1; ex_data = 16'h0000; ex_is_load = 1'b1;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    rst = 1'b1;
    rd_addr = {3'd3, 3'd1};
    mem_data = 16'hDEAD;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_hit !== 2'b00) begin
      errors++; $display("FAIL rst_mid got stall %b hit %b want 0 00", stall, fwd_hit);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", stall_cnt); end
    step();
    checks++;
    if (fwd_hit !== 2'b00 || fwd_data !== 32'h1111_2222) begin
      errors++; $display("FAIL rst_dropped got hit %b data %h want 00 11112222", fwd_hit, fwd_data);
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    ex_valid = 1'b1; ex_dest = 3'd1; ex_data = 16'h0000; ex_is_load = 1'b1;
    rd_addr = {3'd3, 3'd1};
    mem_data = 16'h0042;
    for (int cyc = 0; cyc < 200 && n < 19; cyc++) begin
      if (stall) n++;
      step();
    end
    ex_valid = 1'b0; ex_is_load = 1'b0;
    checks++;
    if (n != 19) begin errors++; $display("FAIL sat_budget got %0d stalls want 19", n); end
    checks++;
    if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt got %0d want 15", stall_cnt); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
